systolic_out_drain: RTL

Output-side drain unit for the systolic array. It captures the array's per-column result bus, `outs_array`, one row-slice per cycle into a rows×cols register buffer, with optional ReLU applied on capture. It then serializes the stored results one word at a time over a valid/ready stream. It is the counterpart of the serially loaded input/weight buffers on the array's front end, and it replaces the array's unused output-buffer chain.

---
 rtl/systolic_out_drain.sv | 125 ++++++++++++
 1 files changed

// File: rtl/systolic_out_drain.sv
// Output drain for the systolic array: captures rows x cols result slices
// (optional ReLU on capture), then streams them row-major over valid/ready.
module systolic_out_drain #(
  parameter int width = 16,
  parameter int rows  = 4,
  parameter int cols  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  relu_en,
  input  logic                  cap_en,
  input  logic [cols*width-1:0] outs_array,
  output logic [width-1:0]      out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [7:0]            out_idx,
  output logic                  busy,
  output logic                  done
);

  localparam int RW = (rows > 1) ? $clog2(rows) : 1;
  localparam int NW = rows * cols;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    DRAIN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [RW-1:0]    row_cnt_q, row_cnt_d;
  logic [7:0]       idx_q, idx_d;
  logic             relu_q, relu_d;
  logic [width-1:0] buf_q [NW];
  logic [width-1:0] buf_d [NW];
  logic [width-1:0] slice;
  logic [width-1:0] rd_word;

  always_comb begin
    state_d   = state_q;
    row_cnt_d = row_cnt_q;
    idx_d     = idx_q;
    relu_d    = relu_q;
    buf_d     = buf_q;
    slice     = '0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = CAPTURE;
          row_cnt_d = '0;
          idx_d     = '0;
          relu_d    = relu_en;
        end
      end
      CAPTURE: begin
        if (cap_en) begin
          // Constant-index write per (row, col) keeps the row select a plain compare.
          for (int unsigned r = 0; r < rows; r++) begin
            for (int unsigned c = 0; c < cols; c++) begin
              if (row_cnt_q == RW'(r)) begin
                slice = outs_array[c*width +: width];
                buf_d[r*cols + c] = (relu_q && slice[width-1]) ? '0 : slice;
              end
            end
          end
          row_cnt_d = row_cnt_q + 1'b1;
          if (row_cnt_q == RW'(rows - 1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (out_ready) begin
          idx_d = idx_q + 8'd1;
          if (idx_q == 8'(NW - 1)) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // idx equals row*cols+col, so it addresses the flattened buffer directly.
  always_comb begin
    rd_word = '0;
    for (int unsigned i = 0; i < NW; i++) begin
      if (idx_q == 8'(i)) begin
        rd_word = buf_q[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      row_cnt_q <= '0;
      idx_q     <= '0;
      relu_q    <= 1'b0;
      for (int unsigned i = 0; i < NW; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      row_cnt_q <= row_cnt_d;
      idx_q     <= idx_d;
      relu_q    <= relu_d;
      buf_q     <= buf_d;
    end
  end

  assign out       = rd_word;
  assign out_valid = (state_q == DRAIN);
  assign out_idx   = idx_q;
  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);

endmodule
